sram_word_ctrl: RTL and testbench
=================================

SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

Interface
REQ-001 Parameter WORD_W, default 27: width of a user data word.
REQ-002 Parameter ADDR_W, default 9: width of the user word address.
REQ-003 Parameter DATA_W, default 8: width of the external SRAM data bus.
REQ-004 Parameter WAIT_CYC, default 2: clk cycles in each of the SETUP and STROBE phases (>=1).
REQ-005 Derived constants: BEATS = ceil(WORD_W/DATA_W); BW = clog2(BEATS) (1 when BEATS=1); RAM address width RA_W = ADDR_W+BW.
REQ-006 clk  in  1  single system clock; all state changes on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  controller idle; a request is accepted on an edge with req_valid & req_ready.
REQ-010 req_we  in  1  1 = write, 0 = read; sampled at acceptance.
REQ-011 req_addr  in  ADDR_W  word address; sampled at acceptance.
REQ-012 req_wdata  in  WORD_W  write word; sampled at acceptance.
REQ-013 rsp_valid  out  1  transaction complete; held until rsp_ready.
REQ-014 rsp_ready  in  1  response consumer ready.
REQ-015 rsp_rdata  out  WORD_W  read word; unchanged by writes.
REQ-016 ram_a  out  RA_W  SRAM byte address {word_addr, beat_index}.
REQ-017 ram_d  inout  DATA_W  SRAM data bus.
REQ-018 ram_ce1_n, ram_ce2, ram_we_n, ram_oe_n  out  1 each  SRAM chip enables (active low/high) and active-low write/output strobes.

Function
REQ-019 States: IDLE, SETUP, STROBE, HOLD, RESP; req_ready = 1 only in IDLE.
REQ-020 Acceptance latches addr, we and wdata, clears beat index to 0, and moves IDLE->SETUP.
REQ-021 SETUP lasts WAIT_CYC cycles: ram_a valid, ram_ce1_n=0, ram_ce2=1, strobes high; write drives ram_d with the current beat.
REQ-022 STROBE lasts WAIT_CYC cycles: ram_we_n=0 (write) or ram_oe_n=0 (read); ram_a and ram_d stable.
REQ-023 Read captures ram_d into beat register on the last STROBE cycle edge.
REQ-024 HOLD lasts 1 cycle: strobes high, ram_a/ram_d held, chip enables asserted; then SETUP of beat+1, or RESP after beat BEATS-1.
REQ-025 Beat packing is MSB-first: beat k = wdata[WORD_W-1-k*DATA_W -: DATA_W]; last beat left-aligned, unused low bits driven 0.
REQ-026 Read reassembly is the exact inverse; pad bits of the last beat are discarded.
REQ-027 rsp_valid rises BEATS*(2*WAIT_CYC+1) cycles after the acceptance edge (20 with defaults).
REQ-028 RESP: rsp_valid=1, rsp_rdata stable, chip enables deasserted; leave to IDLE on edge with rsp_ready=1, so minimum request-to-request spacing is one RESP cycle.
REQ-029 ram_d is high-Z except during SETUP/STROBE/HOLD of a write transaction.
REQ-030 ram_we_n and ram_oe_n are never both low; the strobe never falls in the same cycle ram_a changes.
REQ-031 req_valid in non-IDLE states is ignored (no queuing); req_* changes after acceptance have no effect.
REQ-032 Outputs (strobes, enables) are registered; no combinational path from req_* to ram_*.
REQ-033 ram_a in IDLE/RESP holds 0.

Reset
REQ-034 On rst_n=0, immediately: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_a=0, ram_ce1_n=1, ram_ce2=0, ram_we_n=1, ram_oe_n=1, ram_d high-Z.
REQ-035 Reset mid-transaction aborts it: no response is produced and a write may be partial; first request after release is accepted normally.

Verification
REQ-036 Defaults, write addr 0x1F5 data 0x7FFFFFF -> SRAM model sees bytes FF,FF,FF,E0 at 0x7D4..0x7D7, one ram_we_n pulse of 2 cycles each, rsp_valid at cycle 20.
REQ-037 Write addr 0x003 data 0x0000001, then read 0x003 -> bytes 00,00,00,20 at 0x00C..0x00F; rsp_rdata = 0x0000001.
REQ-038 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5, req_ready=0, new req_valid ignored until RESP exits.
REQ-039 rst_n pulsed low during STROBE of beat 2 of a write -> ram_we_n=1 and ram_d=Z asynchronously, rsp_valid never asserted, next read completes correctly.
REQ-040 WORD_W=16, DATA_W=8, WAIT_CYC=1 -> BEATS=2, RA_W=ADDR_W+1, rsp_valid at cycle 6; write 0xA55A read back 0xA55A.
REQ-041 Throughout all tests: assertion that ram_d is driven only in write phases and ram_we_n & ram_oe_n never both low.

Source files
------------

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: moves one WORD_W-bit user word to or from an asynchronous
// byte-wide (DATA_W) SRAM as BEATS sequential beats. Each beat runs through
// SETUP (WAIT_CYC cycles), STROBE (WAIT_CYC cycles) and HOLD (1 cycle).
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_we, req_addr, req_wdata request fields, sampled at acceptance
//   rsp_valid/rsp_ready         completion handshake, held until consumed
//   rsp_rdata                   last read word (writes leave it unchanged)
//   ram_a                       SRAM address {word_addr, beat_index}
//   ram_d                       SRAM data bus (driven only during writes)
//   ram_ce1_n, ram_ce2          chip enables
//   ram_we_n, ram_oe_n          write / output strobes
module sram_word_ctrl #(
  parameter int unsigned WORD_W   = 27,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 2,
  localparam int unsigned BEATS   = (WORD_W + DATA_W - 1) / DATA_W,
  localparam int unsigned BW      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned RA_W    = ADDR_W + BW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [RA_W-1:0]   ram_a,
  inout  wire  [DATA_W-1:0] ram_d,
  output logic              ram_ce1_n,
  output logic              ram_ce2,
  output logic              ram_we_n,
  output logic              ram_oe_n
);

  localparam int unsigned BUF_W = BEATS * DATA_W;
  localparam int unsigned PAD   = BUF_W - WORD_W;
  localparam int unsigned CW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StResp} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  // Word buffers are left-aligned: beat 0 sits in the top DATA_W bits and the
  // pad bits of the last beat sit at the bottom.
  logic [BUF_W-1:0]    wbuf_q, wbuf_d;
  logic [BUF_W-1:0]    rbuf_q, rbuf_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  // Registered SRAM-side outputs, computed from next-state values.
  logic [RA_W-1:0]     a_q, a_d;
  logic                ce_q, ce_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                drv_q, drv_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic last_cnt, last_beat;

  assign last_cnt  = (cnt_q == CW'(WAIT_CYC - 1));
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      a_q     <= '0;
      ce_q    <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      drv_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      a_q     <= a_d;
      ce_q    <= ce_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      drv_q   <= drv_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StSetup;
          addr_d  = req_addr;
          we_d    = req_we;
          wbuf_d  = BUF_W'(req_wdata) << PAD;
          beat_d  = '0;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (last_cnt) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStrobe: begin
        if (last_cnt) begin
          state_d = StHold;
          cnt_d   = '0;
          // Sample the bus on the final strobe edge, while ram_oe_n is still low.
          if (!we_q) begin
            rbuf_d[BUF_W - 1 - int'(beat_q) * DATA_W -: DATA_W] = ram_d;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StHold: begin
        if (last_beat) begin
          state_d = StResp;
          if (!we_q) begin
            rdata_d = WORD_W'(rbuf_q >> PAD);
          end
        end else begin
          state_d = StSetup;
          beat_d  = beat_q + BW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: SRAM controls for the cycle after the coming edge.
  always_comb begin
    a_d    = '0;
    ce_d   = 1'b0;
    we_n_d = 1'b1;
    oe_n_d = 1'b1;
    drv_d  = 1'b0;
    dout_d = '0;
    case (state_d)
      StSetup, StStrobe, StHold: begin
        a_d    = {addr_d, beat_d};
        ce_d   = 1'b1;
        drv_d  = we_d;
        dout_d = wbuf_d[BUF_W - 1 - int'(beat_d) * DATA_W -: DATA_W];
        if (state_d == StStrobe) begin
          we_n_d = ~we_d;
          oe_n_d = we_d;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign ram_a     = a_q;
  assign ram_ce1_n = ~ce_q;
  assign ram_ce2   = ce_q;
  assign ram_we_n  = we_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_d     = drv_q ? dout_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: a default-parameter instance (27-bit words, 4 beats)
// and a 16-bit / WAIT_CYC=1 instance, each with a simple async SRAM model.
module tb_sram_word_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUT A: defaults ----------------
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic [8:0]  a_req_addr;
  logic [26:0] a_req_wdata, a_rsp_rdata;
  logic [10:0] a_ram_a;
  wire  [7:0]  a_ram_d;
  logic        a_ce1_n, a_ce2, a_we_n, a_oe_n;

  sram_word_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .ram_a     (a_ram_a),
    .ram_d     (a_ram_d),
    .ram_ce1_n (a_ce1_n),
    .ram_ce2   (a_ce2),
    .ram_we_n  (a_we_n),
    .ram_oe_n  (a_oe_n)
  );

  logic [7:0] mem_a [0:2047];
  always @(posedge clk) if (!a_ce1_n && a_ce2 && !a_we_n) mem_a[a_ram_a] <= a_ram_d;
  assign a_ram_d = (!a_ce1_n && a_ce2 && !a_oe_n) ? mem_a[a_ram_a] : 8'hzz;

  // ---------------- DUT B: 16-bit word, one wait cycle ----------------
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [8:0]  b_req_addr;
  logic [15:0] b_req_wdata, b_rsp_rdata;
  logic [9:0]  b_ram_a;
  wire  [7:0]  b_ram_d;
  logic        b_ce1_n, b_ce2, b_we_n, b_oe_n;

  sram_word_ctrl #(
    .WORD_W   (16),
    .ADDR_W   (9),
    .DATA_W   (8),
    .WAIT_CYC (1)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .ram_a     (b_ram_a),
    .ram_d     (b_ram_d),
    .ram_ce1_n (b_ce1_n),
    .ram_ce2   (b_ce2),
    .ram_we_n  (b_we_n),
    .ram_oe_n  (b_oe_n)
  );

  logic [7:0] mem_b [0:1023];
  always @(posedge clk) if (!b_ce1_n && b_ce2 && !b_we_n) mem_b[b_ram_a] <= b_ram_d;
  assign b_ram_d = (!b_ce1_n && b_ce2 && !b_oe_n) ? mem_b[b_ram_a] : 8'hzz;

  // ---------------- scoreboards and reference state ----------------
  logic [26:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic [26:0] shadow_a [0:511];
  logic [15:0] shadow_b [0:511];
  logic [26:0] last_rd_a = '0;
  logic [15:0] last_rd_b = '0;
  logic        cur_we_a = 1'b0;
  logic        cur_we_b = 1'b0;
  int          we_low_a = 0;
  int          we_pulses_a = 0;
  logic        we_n_prev_a = 1'b1;

  // Bus-protocol watch: strobes never both low; controller drives ram_d only
  // while a write transaction is in flight.
  always @(negedge clk) begin
    chk("a_strobe_excl", {31'b0, a_we_n | a_oe_n}, 32'd1);
    chk("b_strobe_excl", {31'b0, b_we_n | b_oe_n}, 32'd1);
    if (a_oe_n)
      chk("a_d_drive", {31'b0, a_ram_d !== 8'hzz},
          {31'b0, !a_req_ready && !a_rsp_valid && cur_we_a});
    if (b_oe_n)
      chk("b_d_drive", {31'b0, b_ram_d !== 8'hzz},
          {31'b0, !b_req_ready && !b_rsp_valid && cur_we_b});
    if (!a_we_n) we_low_a++;
    if (we_n_prev_a && !a_we_n) we_pulses_a++;
    we_n_prev_a = a_we_n;
  end

  task automatic txn_a(input logic we, input logic [8:0] addr, input logic [26:0] wd,
                       input int hold);
    int          n;
    int          lat;
    logic [26:0] held;
    n = 0;
    @(negedge clk);
    while (!a_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_ready_wait", {31'b0, a_req_ready}, 32'd1);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wd;
    if (we) begin
      shadow_a[addr] = wd;
      exp_a_q.push_back(last_rd_a);
    end else begin
      last_rd_a = shadow_a[addr];
      exp_a_q.push_back(last_rd_a);
    end
    @(posedge clk);
    cur_we_a    = we;
    we_low_a    = 0;
    we_pulses_a = 0;
    #1;
    // Scramble the request fields after acceptance; they must have no effect.
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_addr  = ~addr;
    a_req_wdata = ~wd;
    lat = 0;
    while (!a_rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("a_latency", lat, 32'd20);
    held = a_rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      a_req_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("a_hold_valid", {31'b0, a_rsp_valid}, 32'd1);
      chk("a_hold_rdata", {5'b0, a_rsp_rdata}, {5'b0, held});
      chk("a_hold_busy", {31'b0, a_req_ready}, 32'd0);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    chk("a_rsp_rdata", {5'b0, a_rsp_rdata}, {5'b0, exp_a_q.pop_front()});
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b0;
    chk("a_rsp_exit", {30'b0, a_req_ready, a_rsp_valid}, 32'd2);
  endtask

  task automatic txn_b(input logic we, input logic [8:0] addr, input logic [15:0] wd);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!b_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready_wait", {31'b0, b_req_ready}, 32'd1);
    b_req_valid = 1'b1;
    b_req_we    = we;
    b_req_addr  = addr;
    b_req_wdata = wd;
    if (we) begin
      shadow_b[addr] = wd;
      exp_b_q.push_back(last_rd_b);
    end else begin
      last_rd_b = shadow_b[addr];
      exp_b_q.push_back(last_rd_b);
    end
    @(posedge clk);
    cur_we_b = we;
    #1;
    b_req_valid = 1'b0;
    b_req_wdata = ~wd;
    lat = 0;
    while (!b_rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b_latency", lat, 32'd6);
    b_rsp_ready = 1'b1;
    chk("b_rsp_rdata", {16'b0, b_rsp_rdata}, {16'b0, exp_b_q.pop_front()});
    @(posedge clk);
    #1;
    b_rsp_ready = 1'b0;
    chk("b_rsp_exit", {30'b0, b_req_ready, b_rsp_valid}, 32'd2);
  endtask

  initial begin
    logic [7:0]  bytes_a [4];
    logic [7:0]  bytes_c [4];
    logic [26:0] rnd;
    int          n;
    logic        saw;

    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {5'b0, a_rsp_rdata}, 32'd0);
    chk("rst_ram_a", {21'b0, a_ram_a}, 32'd0);
    chk("rst_ctrl", {28'b0, a_ce1_n, a_ce2, a_we_n, a_oe_n}, 32'hB);
    chk("rst_d_z", {31'b0, a_ram_d === 8'hzz}, 32'd1);
    chk("rst_b_ctrl", {28'b0, b_ce1_n, b_ce2, b_we_n, b_oe_n}, 32'hB);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones word: bytes FF,FF,FF,E0; four 2-cycle write pulses.
    txn_a(1'b1, 9'h1F5, 27'h7FFFFFF, 0);
    chk("a_we_pulses", we_pulses_a, 32'd4);
    chk("a_we_low_cyc", we_low_a, 32'd8);
    bytes_a = '{8'hFF, 8'hFF, 8'hFF, 8'hE0};
    for (int i = 0; i < 4; i++) chk("a_mem_1f5", {24'b0, mem_a[11'h7D4 + i]}, {24'b0, bytes_a[i]});

    // Single low bit ends up left-aligned in the last beat.
    txn_a(1'b1, 9'h003, 27'h0000001, 0);
    bytes_c = '{8'h00, 8'h00, 8'h00, 8'h20};
    for (int i = 0; i < 4; i++) chk("a_mem_003", {24'b0, mem_a[11'h00C + i]}, {24'b0, bytes_c[i]});
    txn_a(1'b0, 9'h003, 27'h0, 0);

    // Read held in RESP for 5 cycles with new requests pending.
    txn_a(1'b0, 9'h1F5, 27'h0, 5);

    // Random word round trip.
    rnd = 27'($urandom());
    txn_a(1'b1, 9'h0AA, rnd, 0);
    txn_a(1'b0, 9'h0AA, 27'h0, 0);

    // Reset during STROBE of beat 2 of a write.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h100; a_req_wdata = 27'h5A5A5A5;
    @(posedge clk);
    cur_we_a = 1'b1;
    #1 a_req_valid = 1'b0;
    n = 0;
    while (!(a_ram_a[1:0] == 2'd2 && !a_we_n) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reach_b2", {29'b0, a_ram_a[1:0], a_we_n}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", {31'b0, a_we_n}, 32'd1);
    chk("abort_d_z", {31'b0, a_ram_d === 8'hzz}, 32'd1);
    chk("abort_ce1_n", {31'b0, a_ce1_n}, 32'd1);
    chk("abort_idle", {30'b0, a_req_ready, a_rsp_valid}, 32'd2);
    last_rd_a = '0;
    last_rd_b = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 saw |= a_rsp_valid;
    end
    chk("abort_no_rsp", {31'b0, saw}, 32'd0);
    txn_a(1'b0, 9'h003, 27'h0, 0);

    // Two-beat configuration.
    txn_b(1'b1, 9'h005, 16'hA55A);
    chk("b_mem_hi", {24'b0, mem_b[10'h00A]}, 32'hA5);
    chk("b_mem_lo", {24'b0, mem_b[10'h00B]}, 32'h5A);
    txn_b(1'b0, 9'h005, 16'h0);
    txn_b(1'b1, 9'h1FF, 16'h0F0F);
    txn_b(1'b0, 9'h1FF, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
